inspeccion_scheduler: RTL
=========================

// Module: inspeccion_scheduler
// PURPOSE
//  Shares one inspection station (the P/RI Moore inspection FSM + Mealy protocol pair) among
//  N_LANES conveyor lanes. Round-robin grant, part-settle delay, one-cycle start pulse,
//  done wait with timeout, result classification and pass/fail/timeout tallies.
//  Sits above the inspection FSMs in the tt_um_erickespa top; drives P, samples the result.
// PARAMETERS
//  N_LANES      4    number of requesting lanes (2..8)
//  SETTLE_CYC   3    cycles between grant and insp_start (>=1)
//  TIMEOUT_CYC  15   max cycles in INSPECT waiting for insp_done (>=1)
//  CNT_W        8    width of pass/fail counters
// PORTS
//  clk           in   1        system clock, rising edge
//  rst           in   1        asynchronous reset, active-low
//  enable        in   1        1 = new grants allowed; 0 = finish in-flight job, then hold IDLE
//  lane_req      in   N_LANES  level: part present at lane i
//  insp_done     in   1        station finished (1-cycle pulse)
//  insp_pass     in   1        verdict, valid with insp_done (1 = pass)
//  clr_err       in   1        clears err_timeout
//  lane_grant    out  N_LANES  one-hot, held from grant until job ends
//  insp_start    out  1        1-cycle pulse: drives station P
//  result_valid  out  1        1-cycle pulse in RESULT
//  result_code   out  2        00 none, 01 pass, 10 fail, 11 timeout (valid with result_valid)
//  lane_release  out  1        high in RELEASE: lane may move the part out
//  pass_cnt      out  CNT_W    saturating count of passes
//  fail_cnt      out  CNT_W    saturating count of fails + timeouts
//  err_timeout   out  1        sticky, set on any timeout
//  busy          out  1        state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, rr pointer 0, all outputs 0, counters 0, err cleared.
//  FSM: IDLE -> SETTLE -> INSPECT -> RESULT -> RELEASE -> IDLE.
//  IDLE: if enable && |lane_req: pick first requesting lane at/after pointer (wrapping);
//   lane_grant registered next edge, go SETTLE. No request: stay, outputs 0.
//  SETTLE: count SETTLE_CYC cycles; last cycle -> INSPECT. If granted lane_req drops:
//   abort to IDLE, grant cleared, pointer = granted+1, no result, no count.
//  INSPECT: insp_start=1 on first cycle only. Wait insp_done; timer counts cycles in state.
//   insp_done seen -> RESULT, code 01/10 from insp_pass. Timer reaches TIMEOUT_CYC without
//   done -> RESULT, code 11. done on the expiry cycle: done wins. lane_req drop ignored here.
//  RESULT: exactly 1 cycle; result_valid=1; pass -> pass_cnt+1; fail/timeout -> fail_cnt+1;
//   counters saturate at 2^CNT_W-1 (no wrap); timeout sets err_timeout.
//  RELEASE: lane_release=1 while granted lane_req=1; when it drops -> IDLE, grant cleared,
//   pointer = granted+1 mod N_LANES.
//  Latency: req seen in IDLE at edge k -> grant at k+1 -> insp_start high cycle k+1+SETTLE_CYC.
//  err_timeout: clr_err clears; set has priority over clr_err in the same cycle.
//  Stray insp_done outside INSPECT: ignored. enable=0 never aborts an in-flight job.
//  Async reset mid-job: everything returns to reset values immediately; no result emitted.
// STRUCTURE
//  Package inspeccion_pkg: state enum (IDLE,SETTLE,INSPECT,RESULT,RELEASE), result codes
//   RES_NONE/PASS/FAIL/TIMEOUT (2-bit, shared with the Mealy protocol encoding).
//  Sub-module rr_arbiter #(N): combinational req + pointer -> one-hot grant, grant index.
//  Top of block: FSM, settle/timeout counter (shared, reloaded per state), tallies, err flag.
// TESTING
//  1 lane_req=0001, insp_done+pass 2 cyc after start -> grant 0001, start at k+4, code 01, pass_cnt=1.
//  2 lane_req=1111 held, each job passes -> grant order 0001,0010,0100,1000,0001 (rr wrap).
//  3 no insp_done -> code 11 after 15 INSPECT cycles, fail_cnt=1, err_timeout=1; clr_err -> 0.
//  4 lane 2 req drops during SETTLE -> back to IDLE, no start, no result, next grant lane 3.
//  5 insp_done on the timeout cycle with pass=1 -> code 01, err_timeout stays 0.
//  6 rst low during INSPECT -> all outputs 0 same cycle; fail_cnt at 255 + fail -> stays 255.

Source files
------------

// File: rtl/inspeccion_pkg.sv
// Shared constants for the inspection-station scheduler.
//   State encodings for the scheduler FSM, plus the 2-bit result codes. The result
//   codes use the same encoding as the station's Mealy protocol side, so values can
//   be passed between the two without translation.
package inspeccion_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_INSPECT = 3'd2;
  localparam logic [2:0] ST_RESULT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_FAIL    = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req         in   N   request vector
//   ptr         in   PW  lane with highest priority this round
//   grant       out  N   one-hot grant (0 when no request)
//   grant_idx   out  PW  index of the granted lane
//   grant_valid out  1   at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan offsets from the far end back towards ptr so the closest requester at or
  // after ptr is the last one written and therefore wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inspeccion_scheduler.sv
// Shares one inspection station among N_LANES conveyor lanes.
//   Round-robin lane grant, part-settle delay, one-cycle start pulse to the station,
//   done wait with timeout, result classification and saturating pass/fail tallies.
// Ports:
//   clk, rst (async, active-low)
//   enable        new grants allowed (an in-flight job always completes)
//   lane_req      level request per lane (part present)
//   insp_done/insp_pass  station verdict pulse
//   clr_err       clears the sticky timeout flag
//   lane_grant    one-hot, held for the whole job
//   insp_start    one-cycle start pulse to the station
//   result_valid/result_code  one-cycle classified result
//   lane_release  granted lane may move its part out
//   pass_cnt, fail_cnt, err_timeout, busy
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no job; grant the next requesting lane when enabled
// ST_SETTLE  | part settling for SETTLE_CYC cycles; request drop aborts
// ST_INSPECT | start pulsed on first cycle; wait done or TIMEOUT_CYC cycles
// ST_RESULT  | one cycle: publish result, update tallies and error flag
// ST_RELEASE | hold grant until the granted lane drops its request
module inspeccion_scheduler
  import inspeccion_pkg::*;
#(
  parameter int N_LANES     = 4,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_LANES-1:0] lane_req,
  input  logic               insp_done,
  input  logic               insp_pass,
  input  logic               clr_err,
  output logic [N_LANES-1:0] lane_grant,
  output logic               insp_start,
  output logic               result_valid,
  output logic [1:0]         result_code,
  output logic               lane_release,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               err_timeout,
  output logic               busy
);

  localparam int PW   = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int TMAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    SETTLE_LD  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0]    LAST_LANE  = PW'(N_LANES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [2:0]         state_q, state_d;
  logic [N_LANES-1:0] grant_q, grant_d;
  logic [PW-1:0]      gidx_q,  gidx_d;
  logic [PW-1:0]      ptr_q,   ptr_d;
  logic [TW-1:0]      tmr_q,   tmr_d;
  logic [1:0]         code_q,  code_d;
  logic [CNT_W-1:0]   pass_q,  pass_d;
  logic [CNT_W-1:0]   fail_q,  fail_d;
  logic               err_q,   err_d;

  logic [N_LANES-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_valid;
  logic               granted_req;
  logic               err_set;
  logic [PW-1:0]      ptr_after;

  rr_arbiter #(.N(N_LANES), .PW(PW)) u_arb (
    .req         (lane_req),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign granted_req  = lane_req[gidx_q];
  assign ptr_after    = (gidx_q == LAST_LANE) ? '0 : gidx_q + 1'b1;

  assign lane_grant   = grant_q;
  assign busy         = (state_q != ST_IDLE);
  // The timer is freshly loaded on INSPECT entry, so the load value marks cycle one.
  assign insp_start   = (state_q == ST_INSPECT) && (tmr_q == TIMEOUT_LD);
  assign result_valid = (state_q == ST_RESULT);
  assign result_code  = result_valid ? code_q : RES_NONE;
  assign lane_release = (state_q == ST_RELEASE) && granted_req;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign err_timeout  = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && arb_valid) begin
          state_d = ST_SETTLE;
          grant_d = arb_grant;
          gidx_d  = arb_idx;
          tmr_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (!granted_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_after;
        end else if (tmr_q == '0) begin
          state_d = ST_INSPECT;
          tmr_d   = TIMEOUT_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_INSPECT: begin
        // done is checked first so a verdict on the expiry cycle still counts
        if (insp_done) begin
          state_d = ST_RESULT;
          code_d  = insp_pass ? RES_PASS : RES_FAIL;
        end else if (tmr_q == '0) begin
          state_d = ST_RESULT;
          code_d  = RES_TIMEOUT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RESULT: begin
        state_d = ST_RELEASE;
        if (code_q == RES_PASS) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        end
        err_set = (code_q == RES_TIMEOUT);
      end
      ST_RELEASE: begin
        if (!granted_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_after;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      tmr_q   <= '0;
      code_q  <= RES_NONE;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

endmodule
